irq_controller: RTL

Memory-mapped interrupt controller between the timer/UART/switch event sources and the CPU's single IRQ input.
- Latches per-source events and applies enable masks.
- Picks one source by fixed priority and drives irqout to the control unit.
- Holds further requests off until software writes EOI.
- Sits on the peripheral bus (rd/wr/addr/wdata/rdata) beside the existing peripheral block. The CPU's PC[31] (kernel-mode flag) tells it when the interrupt has been taken.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 26 ++
 rtl/irq_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_pkg: register map, FSM states and field positions for        |
// | irq_controller.                                  Rev 1.0         |
// +------------------------------------------------------------------+
package irq_pkg;

  localparam logic [1:0] OFS_IE    = 2'd0;
  localparam logic [1:0] OFS_IP    = 2'd1;
  localparam logic [1:0] OFS_CAUSE = 2'd2;
  localparam logic [1:0] OFS_EOI   = 2'd3;

  localparam int GE_BIT      = 31;
  localparam int CNT_CLR_BIT = 30;
  localparam int CNT_LSB     = 8;
  localparam int CNT_MSB     = 23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_prio_enc: lowest-index-wins priority encoder (id + valid).   |
// |                                                  Rev 1.0         |
// +------------------------------------------------------------------+
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [3:0]         id,
  output logic               valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = 4'd0;
    valid = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_controller: edge-latched, fixed-priority interrupt controller |
// | with EOI handshake. Optional IRQ_CNT_EN adds a dropped-event ctr. |
// |                                                  Rev 1.0         |
// +------------------------------------------------------------------+
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0040
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               pc31,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irqout,
  output logic [3:0]         cause
);

  irq_state_e         r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_ie, r_ip, r_prev;
  logic [NUM_SRC-1:0] w_edge, w_w1c, w_svc_clr, w_clr, w_pend;
  logic               r_ge;
  logic [3:0]         r_cause, w_win_id;
  logic               w_win_vld, w_hit, w_ie_wr, w_ip_wr, w_eoi_wr;
  logic [31:0]        w_cnt_word;
  logic               unused_bits;

  assign w_hit    = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_ie_wr  = wr && w_hit && (addr[3:2] == OFS_IE);
  assign w_ip_wr  = wr && w_hit && (addr[3:2] == OFS_IP);
  assign w_eoi_wr = wr && w_hit && (addr[3:2] == OFS_EOI);

  assign w_edge = src_irq & ~r_prev;
  assign w_w1c  = w_ip_wr ? wdata[NUM_SRC-1:0] : '0;
  assign w_clr  = w_w1c | w_svc_clr;
  assign w_pend = r_ip & r_ie;
  assign cause  = r_cause;

  assign unused_bits = ^{addr[1:0], wdata};

  // Taking the interrupt retires the in-service source's pending bit.
  always_comb begin
    w_svc_clr = '0;
    if (r_state == ASSERT && pc31) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        w_svc_clr[i] = (r_cause == 4'(i));
      end
    end
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req   (w_pend),
    .id    (w_win_id),
    .valid (w_win_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    irqout      = 1'b0;
    case (r_state)
      IDLE:    if (r_ge && w_win_vld) w_state_nxt = ASSERT;
      ASSERT: begin
        irqout = 1'b1;
        if (pc31) w_state_nxt = SERVICE;
      end
      SERVICE: if (w_eoi_wr) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new edge is OR-ed in after the clear so that set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie    <= '0;
      r_ge    <= 1'b0;
      r_ip    <= '0;
      r_prev  <= '0;
      r_cause <= 4'd0;
    end else begin
      r_prev <= src_irq;
      r_ip   <= (r_ip & ~w_clr) | w_edge;
      if (r_state == IDLE && w_state_nxt == ASSERT) r_cause <= w_win_id;
      if (w_ie_wr) begin
        r_ie <= wdata[NUM_SRC-1:0];
        r_ge <= wdata[GE_BIT];
      end
    end
  end

`ifdef IRQ_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop     = |(w_edge & r_ip & ~w_clr);
  assign w_cnt_word = 32'(r_drop_cnt) << CNT_LSB;

  always_ff @(posedge clk) begin
    if (reset)                                r_drop_cnt <= 16'd0;
    else if (w_ie_wr && wdata[CNT_CLR_BIT])   r_drop_cnt <= 16'd0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
`else
  assign w_cnt_word = 32'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    if (rd && w_hit) begin
      case (addr[3:2])
        OFS_IE:    rdata = 32'(r_ie) | (32'(r_ge) << GE_BIT) | w_cnt_word;
        OFS_IP:    rdata = 32'(r_ip);
        OFS_CAUSE: rdata = 32'(r_cause);
        default:   rdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire
